// File: rtl/decode_queue_pkg.sv
// decode_queue shared types: widths, internal op codes,
// RV32I major opcodes and the issue-register bundle.
package decode_queue_pkg;

  localparam int PcLength     = 31;
  localparam int DataLength   = 31;
  localparam int OpcodeLength = 5;

  typedef enum logic [OpcodeLength:0] {
    OP_NOP     = 6'd0,
    OP_LUI     = 6'd1,
    OP_AUIPC   = 6'd2,
    OP_JAL     = 6'd3,
    OP_JALR    = 6'd4,
    OP_BEQ     = 6'd5,
    OP_BNE     = 6'd6,
    OP_BLT     = 6'd7,
    OP_BGE     = 6'd8,
    OP_BLTU    = 6'd9,
    OP_BGEU    = 6'd10,
    OP_LB      = 6'd11,
    OP_LH      = 6'd12,
    OP_LW      = 6'd13,
    OP_LBU     = 6'd14,
    OP_LHU     = 6'd15,
    OP_SB      = 6'd16,
    OP_SH      = 6'd17,
    OP_SW      = 6'd18,
    OP_ADDI    = 6'd19,
    OP_SLTI    = 6'd20,
    OP_SLTIU   = 6'd21,
    OP_XORI    = 6'd22,
    OP_ORI     = 6'd23,
    OP_ANDI    = 6'd24,
    OP_SLLI    = 6'd25,
    OP_SRLI    = 6'd26,
    OP_SRAI    = 6'd27,
    OP_ADD     = 6'd28,
    OP_SUB     = 6'd29,
    OP_SLL     = 6'd30,
    OP_SLT     = 6'd31,
    OP_SLTU    = 6'd32,
    OP_XOR     = 6'd33,
    OP_SRL     = 6'd34,
    OP_SRA     = 6'd35,
    OP_OR      = 6'd36,
    OP_AND     = 6'd37,
    OP_ILLEGAL = 6'd63
  } op_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic                  empty;
    logic [PcLength:0]     pc;
    logic [OpcodeLength:0] op;
    logic [4:0]            rd;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [DataLength:0]   imm;
  } issue_t;

endpackage

// File: rtl/decode_queue_if.sv
// Fetch / ROB / register-file signal bundle
// for decode_queue.
interface decode_queue_if;

  logic        is_exception_from_rob;
  logic        is_full_from_rob;
  logic        valid_from_fetch;
  logic [31:0] inst_from_fetch;
  logic [31:0] pc_from_fetch;
  logic        ready_to_fetch;
  logic        is_empty_to_rf;
  logic [31:0] pc_to_rf;
  logic [5:0]  op_to_rf;
  logic [4:0]  rd_to_rf;
  logic [4:0]  rs1_to_rf;
  logic [4:0]  rs2_to_rf;
  logic [31:0] imm_to_rf;

  modport slave (
    input  is_exception_from_rob,
    input  is_full_from_rob,
    input  valid_from_fetch,
    input  inst_from_fetch,
    input  pc_from_fetch,
    output ready_to_fetch,
    output is_empty_to_rf,
    output pc_to_rf,
    output op_to_rf,
    output rd_to_rf,
    output rs1_to_rf,
    output rs2_to_rf,
    output imm_to_rf
  );

  modport master (
    output is_exception_from_rob,
    output is_full_from_rob,
    output valid_from_fetch,
    output inst_from_fetch,
    output pc_from_fetch,
    input  ready_to_fetch,
    input  is_empty_to_rf,
    input  pc_to_rf,
    input  op_to_rf,
    input  rd_to_rf,
    input  rs1_to_rf,
    input  rs2_to_rf,
    input  imm_to_rf
  );

endinterface

// File: rtl/decode_queue_inst_decode.sv
// Combinational RV32I decoder: op, operands, immediate,
// and a legal flag for words it cannot decode.
module inst_decode
  import decode_queue_pkg::*;
(
  input  logic [31:0] inst,
  output logic [5:0]  op,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [31:0] imm,
  output logic        legal
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic [31:0] shamt;

  assign opc   = inst[6:0];
  assign f3    = inst[14:12];
  assign f7    = inst[31:25];
  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25],
                  inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7],
                  inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31],
                  inst[19:12], inst[20],
                  inst[30:21], 1'b0};
  assign shamt = {27'b0, inst[24:20]};

  // Major-opcode dispatch, then funct3/funct7 refinement.
  always_comb begin
    op    = OP_NOP;
    rd    = '0;
    rs1   = '0;
    rs2   = '0;
    imm   = '0;
    legal = 1'b1;
    unique case (1'b1)
      (opc == OPC_LUI): begin
        op  = OP_LUI;
        rd  = inst[11:7];
        imm = imm_u;
      end
      (opc == OPC_AUIPC): begin
        op  = OP_AUIPC;
        rd  = inst[11:7];
        imm = imm_u;
      end
      (opc == OPC_JAL): begin
        op  = OP_JAL;
        rd  = inst[11:7];
        imm = imm_j;
      end
      (opc == OPC_JALR): begin
        op    = OP_JALR;
        rd    = inst[11:7];
        rs1   = inst[19:15];
        imm   = imm_i;
        legal = (f3 == 3'b000);
      end
      (opc == OPC_BRANCH): begin
        rs1 = inst[19:15];
        rs2 = inst[24:20];
        imm = imm_b;
        case (f3)
          3'b000:  op = OP_BEQ;
          3'b001:  op = OP_BNE;
          3'b100:  op = OP_BLT;
          3'b101:  op = OP_BGE;
          3'b110:  op = OP_BLTU;
          3'b111:  op = OP_BGEU;
          default: legal = 1'b0;
        endcase
      end
      (opc == OPC_LOAD): begin
        rd  = inst[11:7];
        rs1 = inst[19:15];
        imm = imm_i;
        case (f3)
          3'b000:  op = OP_LB;
          3'b001:  op = OP_LH;
          3'b010:  op = OP_LW;
          3'b100:  op = OP_LBU;
          3'b101:  op = OP_LHU;
          default: legal = 1'b0;
        endcase
      end
      (opc == OPC_STORE): begin
        rs1 = inst[19:15];
        rs2 = inst[24:20];
        imm = imm_s;
        case (f3)
          3'b000:  op = OP_SB;
          3'b001:  op = OP_SH;
          3'b010:  op = OP_SW;
          default: legal = 1'b0;
        endcase
      end
      (opc == OPC_OP_IMM): begin
        rd  = inst[11:7];
        rs1 = inst[19:15];
        imm = imm_i;
        case (f3)
          3'b000: op = OP_ADDI;
          3'b010: op = OP_SLTI;
          3'b011: op = OP_SLTIU;
          3'b100: op = OP_XORI;
          3'b110: op = OP_ORI;
          3'b111: op = OP_ANDI;
          3'b001: begin
            op    = OP_SLLI;
            imm   = shamt;
            legal = (f7 == F7_ZERO);
          end
          default: begin
            imm = shamt;
            if (f7 == F7_ZERO)
              op = OP_SRLI;
            else if (f7 == F7_ALT)
              op = OP_SRAI;
            else
              legal = 1'b0;
          end
        endcase
      end
      (opc == OPC_OP): begin
        rd  = inst[11:7];
        rs1 = inst[19:15];
        rs2 = inst[24:20];
        if (f7 == F7_ZERO) begin
          case (f3)
            3'b000:  op = OP_ADD;
            3'b001:  op = OP_SLL;
            3'b010:  op = OP_SLT;
            3'b011:  op = OP_SLTU;
            3'b100:  op = OP_XOR;
            3'b101:  op = OP_SRL;
            3'b110:  op = OP_OR;
            default: op = OP_AND;
          endcase
        end else if (f7 == F7_ALT && f3 == 3'b000) begin
          op = OP_SUB;
        end else if (f7 == F7_ALT && f3 == 3'b101) begin
          op = OP_SRA;
        end else begin
          legal = 1'b0;
        end
      end
      (opc == OPC_FENCE): begin
        op = OP_NOP;
      end
      (opc == OPC_SYSTEM): begin
        legal = (inst == 32'h0000_0073) ||
                (inst == 32'h0010_0073);
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      op  = OP_NOP;
      rd  = '0;
      rs1 = '0;
      rs2 = '0;
      imm = '0;
    end
  end

endmodule

// File: rtl/decode_queue.sv
// Fetch FIFO + decode + issue register. Optional macro
// DECODE_ILLEGAL_TRAP_EN issues undecodable words as op 63.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int Depth = 8
) (
  input  logic           clk,
  input  logic           rst,
  decode_queue_if.slave  bus
);

  localparam int PW = $clog2(Depth);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FullCnt = CW'(Depth);

  logic [31:0]   inst_q [Depth];
  logic [31:0]   inst_d [Depth];
  logic [31:0]   pc_q   [Depth];
  logic [31:0]   pc_d   [Depth];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  issue_t        iss_q, iss_d;

  logic        ready;
  logic        flush;
  logic        push;
  logic        pop;
  logic [31:0] head_inst;
  logic [5:0]  dec_op;
  logic [4:0]  dec_rd;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [31:0] dec_imm;
  logic        dec_legal;

  assign ready = (count_q != FullCnt);
  assign flush = bus.is_exception_from_rob;
  assign push  = bus.valid_from_fetch && ready &&
                 !flush;
  assign pop   = (count_q != '0) &&
                 !bus.is_full_from_rob && !flush;
  assign head_inst = inst_q[head_q];

  inst_decode u_dec (
    .inst  (head_inst),
    .op    (dec_op),
    .rd    (dec_rd),
    .rs1   (dec_rs1),
    .rs2   (dec_rs2),
    .imm   (dec_imm),
    .legal (dec_legal)
  );

  // FIFO next state: flush clears, else push/pop.
  always_comb begin
    for (int i = 0; i < Depth; i++) begin
      inst_d[i] = inst_q[i];
      pc_d[i]   = pc_q[i];
    end
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        inst_d[tail_q] = bus.inst_from_fetch;
        pc_d[tail_q]   = bus.pc_from_fetch;
        tail_d         = tail_q + PW'(1);
      end
      if (pop)
        head_d = head_q + PW'(1);
      if (push && !pop)
        count_d = count_q + CW'(1);
      else if (pop && !push)
        count_d = count_q - CW'(1);
    end
  end

  // Issue register: empty unless a decodable pop.
  always_comb begin
    iss_d       = iss_q;
    iss_d.empty = 1'b1;
    if (flush) begin
      iss_d       = '0;
      iss_d.empty = 1'b1;
    end else if (pop && dec_legal) begin
      iss_d.empty = 1'b0;
      iss_d.pc    = pc_q[head_q];
      iss_d.op    = dec_op;
      iss_d.rd    = dec_rd;
      iss_d.rs1   = dec_rs1;
      iss_d.rs2   = dec_rs2;
      iss_d.imm   = dec_imm;
    end
`ifdef DECODE_ILLEGAL_TRAP_EN
    else if (pop) begin
      iss_d.empty = 1'b0;
      iss_d.pc    = pc_q[head_q];
      iss_d.op    = OP_ILLEGAL;
      iss_d.rd    = '0;
      iss_d.rs1   = '0;
      iss_d.rs2   = '0;
      iss_d.imm   = head_inst;
    end
`else
`endif
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) begin
        inst_q[i] <= '0;
        pc_q[i]   <= '0;
      end
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      iss_q       <= '0;
      iss_q.empty <= 1'b1;
    end else begin
      for (int i = 0; i < Depth; i++) begin
        inst_q[i] <= inst_d[i];
        pc_q[i]   <= pc_d[i];
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      iss_q   <= iss_d;
    end
  end

  assign bus.ready_to_fetch = ready;
  assign bus.is_empty_to_rf = iss_q.empty;
  assign bus.pc_to_rf       = iss_q.pc;
  assign bus.op_to_rf       = iss_q.op;
  assign bus.rd_to_rf       = iss_q.rd;
  assign bus.rs1_to_rf      = iss_q.rs1;
  assign bus.rs2_to_rf      = iss_q.rs2;
  assign bus.imm_to_rf      = iss_q.imm;

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: issue order, stall,
// wrap-around, flush, illegal words and async reset.
module tb_decode_queue;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  decode_queue_if bus ();

  decode_queue #(.Depth(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_on(input logic [31:0] inst,
                         input logic [31:0] pc);
    bus.valid_from_fetch = 1'b1;
    bus.inst_from_fetch  = inst;
    bus.pc_from_fetch    = pc;
  endtask

  task automatic chk_iss(input string tag,
                         input logic [31:0] pc,
                         input logic [5:0]  op,
                         input logic [4:0]  rd,
                         input logic [4:0]  rs1,
                         input logic [4:0]  rs2,
                         input logic [31:0] imm);
    chk({tag, ".empty"}, 32'(bus.is_empty_to_rf), 32'd0);
    chk({tag, ".pc"}, bus.pc_to_rf, pc);
    chk({tag, ".op"}, 32'(bus.op_to_rf), 32'(op));
    chk({tag, ".rd"}, 32'(bus.rd_to_rf), 32'(rd));
    chk({tag, ".rs1"}, 32'(bus.rs1_to_rf), 32'(rs1));
    chk({tag, ".rs2"}, 32'(bus.rs2_to_rf), 32'(rs2));
    chk({tag, ".imm"}, bus.imm_to_rf, imm);
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, ".empty"}, 32'(bus.is_empty_to_rf), 32'd1);
    chk({tag, ".ready"}, 32'(bus.ready_to_fetch), 32'd1);
    chk({tag, ".pc"}, bus.pc_to_rf, 32'd0);
    chk({tag, ".op"}, 32'(bus.op_to_rf), 32'd0);
    chk({tag, ".rd"}, 32'(bus.rd_to_rf), 32'd0);
    chk({tag, ".rs1"}, 32'(bus.rs1_to_rf), 32'd0);
    chk({tag, ".rs2"}, 32'(bus.rs2_to_rf), 32'd0);
    chk({tag, ".imm"}, bus.imm_to_rf, 32'd0);
  endtask

  function automatic logic [31:0] addi(input int i);
    return (32'(i) << 20) | (32'(i) << 7) | 32'h13;
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    bus.is_exception_from_rob = 1'b0;
    bus.is_full_from_rob      = 1'b0;
    bus.valid_from_fetch      = 1'b0;
    bus.inst_from_fetch       = '0;
    bus.pc_from_fetch         = '0;
    @(negedge clk);
    chk_rst("reset");
    rst = 1'b0;

    // addi x1,x0,5: no bypass, then issue
    push_on(32'h0050_0093, 32'h0);
    tick();
    bus.valid_from_fetch = 1'b0;
    chk("nobypass", 32'(bus.is_empty_to_rf), 32'd1);
    tick();
    chk_iss("addi", 32'h0, 6'd19, 5'd1, 5'd0, 5'd0,
            32'd5);

    // sw, beq, lui back to back
    push_on(32'h0020_A423, 32'h4);
    tick();
    chk("sw.pre", 32'(bus.is_empty_to_rf), 32'd1);
    push_on(32'hFE00_0EE3, 32'h8);
    tick();
    chk_iss("sw", 32'h4, 6'd18, 5'd0, 5'd1, 5'd2,
            32'd8);
    push_on(32'h1234_50B7, 32'hC);
    tick();
    bus.valid_from_fetch = 1'b0;
    chk_iss("beq", 32'h8, 6'd5, 5'd0, 5'd0, 5'd0,
            32'hFFFF_FFFC);
    tick();
    chk_iss("lui", 32'hC, 6'd1, 5'd1, 5'd0, 5'd0,
            32'h1234_5000);
    tick();
    chk("idle", 32'(bus.is_empty_to_rf), 32'd1);

    // stall and fill, 9th refused, drain with wrap
    bus.is_full_from_rob = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("fill.ready", 32'(bus.ready_to_fetch), 32'd1);
      push_on(addi(i), 32'h100 + 32'(4 * i));
      tick();
      chk("fill.empty", 32'(bus.is_empty_to_rf),
          32'd1);
    end
    chk("full.ready", 32'(bus.ready_to_fetch), 32'd0);
    push_on(32'h0090_0493, 32'h200);
    tick();
    bus.valid_from_fetch = 1'b0;
    chk("ninth.ready", 32'(bus.ready_to_fetch), 32'd0);
    bus.is_full_from_rob = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_iss($sformatf("drain%0d", i),
              32'h100 + 32'(4 * i), 6'd19,
              5'(i), 5'd0, 5'd0, 32'(i));
    end
    tick();
    chk("ninth.never", 32'(bus.is_empty_to_rf), 32'd1);

    // flush with 5 queued and a same-cycle push
    bus.is_full_from_rob = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_on(addi(i + 10), 32'h300 + 32'(4 * i));
      tick();
    end
    bus.is_exception_from_rob = 1'b1;
    bus.is_full_from_rob      = 1'b0;
    push_on(addi(9), 32'h400);
    tick();
    bus.is_exception_from_rob = 1'b0;
    bus.valid_from_fetch      = 1'b0;
    chk_rst("flush");
    tick();
    chk("flush.e1", 32'(bus.is_empty_to_rf), 32'd1);
    tick();
    chk("flush.e2", 32'(bus.is_empty_to_rf), 32'd1);
    push_on(32'h0070_0193, 32'h500);
    tick();
    bus.valid_from_fetch = 1'b0;
    tick();
    chk_iss("post", 32'h500, 6'd19, 5'd3, 5'd0, 5'd0,
            32'd7);

    // all-zero word, then a normal addi
    push_on(32'h0000_0000, 32'h600);
    tick();
    push_on(32'h0010_0113, 32'h604);
    tick();
    bus.valid_from_fetch = 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
    chk_iss("illegal", 32'h600, 6'd63, 5'd0, 5'd0,
            5'd0, 32'd0);
`else
    chk("illegal.empty", 32'(bus.is_empty_to_rf),
        32'd1);
    chk("illegal.hold", bus.pc_to_rf, 32'h500);
`endif
    tick();
    chk_iss("after", 32'h604, 6'd19, 5'd2, 5'd0, 5'd0,
            32'd1);

    // sub x5,x6,x7 and srai x1,x2,3
    push_on(32'h4073_02B3, 32'h700);
    tick();
    push_on(32'h4031_5093, 32'h704);
    tick();
    bus.valid_from_fetch = 1'b0;
    chk_iss("sub", 32'h700, 6'd29, 5'd5, 5'd6, 5'd7,
            32'd0);
    tick();
    chk_iss("srai", 32'h704, 6'd27, 5'd1, 5'd2, 5'd0,
            32'd3);

    // async reset mid-stream with 3 queued
    bus.is_full_from_rob = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_on(addi(i + 20), 32'h800 + 32'(4 * i));
      tick();
    end
    bus.valid_from_fetch = 1'b0;
    rst = 1'b1;
    #1;
    chk_rst("async");
    rst = 1'b0;
    bus.is_full_from_rob = 1'b0;
    tick();
    chk("rst.drop1", 32'(bus.is_empty_to_rf), 32'd1);
    tick();
    chk("rst.drop2", 32'(bus.is_empty_to_rf), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/decode_queue.md
# decode_queue

Front-end stage between instruction fetch and the register-file/rename stage. It buffers fetched RV32I instruction words in a small FIFO, decodes the head entry into op/rd/rs1/rs2/imm, and issues one decoded instruction per cycle to the register file. Issue stalls while the ROB is full, and the whole stage flushes when the ROB raises an exception/misprediction.

## Interface
- `Depth`, default 8: FIFO entries; must be a power of two ≥ 2.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `is_exception_from_rob` in 1: flush the stage.
- `is_full_from_rob` in 1: ROB cannot accept an instruction this cycle.
- `valid_from_fetch` in 1: fetch presents an instruction.
- `inst_from_fetch` in 32: instruction word.
- `pc_from_fetch` in 32: instruction PC.
- `ready_to_fetch` out 1: FIFO can accept this cycle.
- `is_empty_to_rf` out 1: 1 means no instruction issued this cycle.
- `pc_to_rf` out 32: PC of the issued instruction.
- `op_to_rf` out 6: internal opcode.
- `rd_to_rf` out 5: destination register; 0 when the instruction has none.
- `rs1_to_rf` out 5: source 1; 0 when unused.
- `rs2_to_rf` out 5: source 2; 0 when unused.
- `imm_to_rf` out 32: decoded immediate.

## Operation
- FIFO: head and tail pointers of `log2(Depth)` bits that wrap modulo `Depth`, plus a registered `count` from 0 to `Depth`.
- `ready_to_fetch = (count != Depth)`. It depends on registered state only; there is no combinational path from the `rf` side.
- Push occurs when `valid_from_fetch && ready_to_fetch && !is_exception_from_rob`.
- Pop (issue) occurs when `count != 0 && !is_full_from_rob && !is_exception_from_rob`.
  - The head entry is decoded and registered onto the `*_to_rf` outputs.
  - `is_empty_to_rf` is driven to 0.
- No pop means `is_empty_to_rf` is driven to 1. All other outputs hold their previous values.
- Simultaneous push and pop leaves `count` unchanged. A push while full cannot occur because `ready` is 0.
- Pushing into an empty FIFO never issues in the same cycle. There is no bypass.
- Flush (`is_exception_from_rob`):
  - Pointers and `count` go to 0.
  - Any same-cycle push is discarded.
  - `is_empty_to_rf` goes to 1 and all other outputs go to 0.
  - Flush has priority over push, pop and stall.
- Decode, per RV32I format:
  - I, S, B and J immediates are sign-extended.
  - The U immediate is `inst[31:12] << 12`.
  - Shift-immediate instructions give a zero-extended 5-bit shamt.
- Field forcing:
  - Branches and stores: `rd` = 0.
  - LUI, AUIPC and JAL: `rs1` = 0.
  - Every format except R, S and B: `rs2` = 0.
  - This guarantees that unused operands read x0.
- Op codes:
  - 0 is NOP.
  - 1–37 are the RV32I instructions in the order listed in `parameters.v`.
  - 63 is ILLEGAL.
  - FENCE, ECALL and EBREAK decode to NOP.

## Timing
- Reset (asynchronous): FIFO empty, `ready_to_fetch` = 1, `is_empty_to_rf` = 1, all other outputs 0.
- Latency: an instruction pushed at edge N appears on the `rf` outputs after edge N+1 at the earliest.
- Throughput: one push and one issue per cycle.
- Rising `is_full_from_rob` blocks the pop at that same edge.
- Deasserting flush resumes normal operation on the next edge.

## Configuration
- `DECODE_ILLEGAL_TRAP_EN` defined:
  - Undecodable words issue as op 63 (ILLEGAL) with `rd` = `rs1` = `rs2` = 0 and `imm` = the raw instruction word.
  - The ROB traps on op 63 at commit.
- Not defined:
  - Undecodable words are popped without issuing; `is_empty_to_rf` = 1 that cycle.
  - Op 63 is never produced.

## Structure
- `parameters.v` holds:
  - widths: `PcLength` = 31, `DataLength` = 31, `OpcodeLength` = 5;
  - op-code macros (NOP, the RV32I set, ILLEGAL);
  - RV32I major-opcode constants.
- Combinational sub-module `inst_decode`:
  - input: `inst` (32);
  - outputs: `op`, `rd`, `rs1`, `rs2`, `imm`, `legal`.
- `decode_queue` holds the FIFO, the issue register and the flush logic.

## Test plan
- Reset, then push `0x00500093` (addi x1,x0,5) at pc 0x0:
  - after the next edge, `is_empty_to_rf` = 0;
  - op = ADDI, rd = 1, rs1 = 0, rs2 = 0, imm = 5, pc = 0.
- Push `0x0020A423` (sw x2,8(x1)), `0xFE000EE3` (beq x0,x0,-4) and `0x123450B7` (lui x1,0x12345) back to back:
  - sw issues with rd = 0, rs1 = 1, rs2 = 2, imm = 8;
  - beq issues with imm = `0xFFFFFFFC`, rd = 0;
  - lui issues with rd = 1, rs1 = 0, imm = `0x12345000`;
  - all three in order, one per cycle.
- Hold `is_full_from_rob` = 1 and push 8 instructions:
  - `ready_to_fetch` = 0 after the 8th push;
  - a 9th valid word is not accepted;
  - releasing the stall issues all 8 in PC order, with wrap-around verified.
- With 5 entries queued, assert `is_exception_from_rob` for one cycle together with a valid push:
  - next cycle `count` = 0, `is_empty_to_rf` = 1, all outputs 0;
  - the pushed word never issues;
  - a new push issues normally afterwards.
- Push `0x00000000`:
  - with `DECODE_ILLEGAL_TRAP_EN`, op = 63 and imm = 0;
  - without it, no issue occurs (`is_empty_to_rf` stays 1) and the following instruction issues next cycle.
- Assert `rst` mid-stream with 3 entries queued: the reset values above appear immediately, without waiting for a clock edge.
